// File: rtl/floor_transit_pkg.sv
// Shared game package: transit FSM states, move
// directions and the stair coordinate table.
package floor_transit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FADE_OUT,
    ST_LOAD,
    ST_PLACE,
    ST_FADE_IN
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_JUMP
  } dir_t;

  // Floors with an explicit stair entry; every
  // other floor reads all-zero coordinates.
  localparam int STAIR_ROWS = 2;

  localparam int STAIR_DOWN_X [STAIR_ROWS] = '{0, 2};
  localparam int STAIR_DOWN_Y [STAIR_ROWS] = '{0, 1};
  localparam int STAIR_UP_X   [STAIR_ROWS] = '{1, 0};
  localparam int STAIR_UP_Y   [STAIR_ROWS] = '{2, 0};

endpackage

// File: rtl/stair_table.sv
// Combinational stair lookup for one floor.
// Ports: floor in; up_x/up_y/down_x/down_y out.
module stair_table
  import floor_transit_pkg::*;
#(
  parameter int FLOOR_W = 16,
  parameter int COORD_W = 4
) (
  input  logic [FLOOR_W-1:0] floor,
  output logic [COORD_W-1:0] up_x,
  output logic [COORD_W-1:0] up_y,
  output logic [COORD_W-1:0] down_x,
  output logic [COORD_W-1:0] down_y
);

  always_comb begin
    up_x   = '0;
    up_y   = '0;
    down_x = '0;
    down_y = '0;
    for (int i = 0; i < STAIR_ROWS; i++) begin
      if (floor == FLOOR_W'(i)) begin
        up_x   = COORD_W'(STAIR_UP_X[i]);
        up_y   = COORD_W'(STAIR_UP_Y[i]);
        down_x = COORD_W'(STAIR_DOWN_X[i]);
        down_y = COORD_W'(STAIR_DOWN_Y[i]);
      end
    end
  end

endmodule

// File: rtl/floor_transit.sv
// Floor transit controller: stairs/jump requests,
// fade out, map load handshake, player placement,
// fade in.
// Ports: clk, rst (async high); up_req, down_req,
// jump_req, jump_floor, map_ack in; floor,
// player_x/y, map_req, fade_level, busy, done,
// reject out.
module floor_transit
  import floor_transit_pkg::*;
#(
  parameter int NUM_FLOORS  = 16,
  parameter int FLOOR_W     = 16,
  parameter int COORD_W     = 4,
  parameter int FADE_STEPS  = 8,
  parameter int FADE_W      = 4,
  parameter int START_FLOOR = 0,
  parameter int START_X     = 0,
  parameter int START_Y     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_req,
  input  logic               down_req,
  input  logic               jump_req,
  input  logic [FLOOR_W-1:0] jump_floor,
  input  logic               map_ack,
  output logic [FLOOR_W-1:0] floor,
  output logic [COORD_W-1:0] player_x,
  output logic [COORD_W-1:0] player_y,
  output logic               map_req,
  output logic [FADE_W-1:0]  fade_level,
  output logic               busy,
  output logic               done,
  output logic               reject
);

  // One extra bit so NUM_FLOORS == 2^FLOOR_W fits.
  localparam logic [FLOOR_W:0] FLOOR_LIMIT =
    (FLOOR_W+1)'(NUM_FLOORS);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR =
    FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FADE_W-1:0] FADE_FULL =
    FADE_W'(FADE_STEPS);
  localparam logic [FADE_W-1:0] FADE_ONE =
    FADE_W'(1);

  state_t state, state_n;
  dir_t   dir, dir_n;

  logic [FLOOR_W-1:0] target, target_n;
  logic [FLOOR_W-1:0] floor_n;
  logic [FADE_W-1:0]  fade_n;
  logic [COORD_W-1:0] px_n, py_n;
  logic               done_n, reject_n;
  logic               multi, jump_bad;

  logic [COORD_W-1:0] up_x, up_y;
  logic [COORD_W-1:0] down_x, down_y;

  // Looks up the current floor; in PLACE that is
  // already the new floor.
  stair_table #(
    .FLOOR_W(FLOOR_W),
    .COORD_W(COORD_W)
  ) u_stairs (
    .floor (floor),
    .up_x  (up_x),
    .up_y  (up_y),
    .down_x(down_x),
    .down_y(down_y)
  );

  assign multi = (up_req & down_req) |
                 (up_req & jump_req) |
                 (down_req & jump_req);

  assign jump_bad =
    ({1'b0, jump_floor} >= FLOOR_LIMIT) ||
    (jump_floor == floor);

  assign busy    = (state != ST_IDLE);
  assign map_req = (state == ST_LOAD);

  always_comb begin
    state_n  = state;
    dir_n    = dir;
    target_n = target;
    floor_n  = floor;
    fade_n   = fade_level;
    px_n     = player_x;
    py_n     = player_y;
    done_n   = 1'b0;
    reject_n = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (multi) begin
          reject_n = 1'b1;
        end else if (up_req) begin
          if (floor == TOP_FLOOR) begin
            reject_n = 1'b1;
          end else begin
            target_n = floor + FLOOR_W'(1);
            dir_n    = DIR_UP;
            state_n  = ST_FADE_OUT;
          end
        end else if (down_req) begin
          if (floor == '0) begin
            reject_n = 1'b1;
          end else begin
            target_n = floor - FLOOR_W'(1);
            dir_n    = DIR_DOWN;
            state_n  = ST_FADE_OUT;
          end
        end else if (jump_req) begin
          if (jump_bad) begin
            reject_n = 1'b1;
          end else begin
            target_n = jump_floor;
            dir_n    = DIR_JUMP;
            state_n  = ST_FADE_OUT;
          end
        end
      end
      ST_FADE_OUT: begin
        fade_n = fade_level - FADE_ONE;
        // Floor switches on the edge the screen
        // goes fully dark.
        if (fade_level == FADE_ONE) begin
          floor_n = target;
          state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (map_ack) begin
          state_n = ST_PLACE;
        end
      end
      ST_PLACE: begin
        // Arriving by going down puts the player on
        // the new floor's up stair, otherwise on
        // its down stair.
        if (dir == DIR_DOWN) begin
          px_n = up_x;
          py_n = up_y;
        end else begin
          px_n = down_x;
          py_n = down_y;
        end
        state_n = ST_FADE_IN;
      end
      ST_FADE_IN: begin
        if (fade_level == FADE_FULL) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end else begin
          fade_n = fade_level + FADE_ONE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      dir        <= DIR_UP;
      target     <= '0;
      floor      <= FLOOR_W'(START_FLOOR);
      fade_level <= FADE_FULL;
      player_x   <= COORD_W'(START_X);
      player_y   <= COORD_W'(START_Y);
      done       <= 1'b0;
      reject     <= 1'b0;
    end else begin
      state      <= state_n;
      dir        <= dir_n;
      target     <= target_n;
      floor      <= floor_n;
      fade_level <= fade_n;
      player_x   <= px_n;
      player_y   <= py_n;
      done       <= done_n;
      reject     <= reject_n;
    end
  end

endmodule

// File: tb/tb_floor_transit.sv
// Self-checking bench for floor_transit with
// FADE_STEPS=4, NUM_FLOORS=16.
module tb_floor_transit;

  localparam int NF = 16;
  localparam int FW = 16;
  localparam int CW = 4;
  localparam int FS = 4;
  localparam int FDW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          up_req, down_req, jump_req;
  logic [FW-1:0] jump_floor;
  logic          map_ack;
  logic [FW-1:0] floor;
  logic [CW-1:0] player_x, player_y;
  logic          map_req;
  logic [FDW-1:0] fade_level;
  logic          busy, done, reject;

  int checks = 0;
  int errors = 0;

  // Reference model: where the player stands.
  int m_floor, m_x, m_y;

  floor_transit #(
    .NUM_FLOORS(NF),
    .FLOOR_W(FW),
    .COORD_W(CW),
    .FADE_STEPS(FS),
    .FADE_W(FDW),
    .START_FLOOR(0),
    .START_X(0),
    .START_Y(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .up_req(up_req),
    .down_req(down_req),
    .jump_req(jump_req),
    .jump_floor(jump_floor),
    .map_ack(map_ack),
    .floor(floor),
    .player_x(player_x),
    .player_y(player_y),
    .map_req(map_req),
    .fade_level(fade_level),
    .busy(busy),
    .done(done),
    .reject(reject)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs();
    return {floor, player_x, player_y, fade_level,
            map_req, busy, done, reject};
  endfunction

  function automatic logic [31:0] vec(
    int fl, int x, int y, int fd,
    bit mr, bit b, bit d, bit r);
    return {16'(fl), 4'(x), 4'(y), 4'(fd),
            mr, b, d, r};
  endfunction

  // Stair table from the game rules.
  function automatic void stairs(
    input int f, input bit want_up,
    output int x, output int y);
    x = 0;
    y = 0;
    if (f == 0 && want_up) begin
      x = 1; y = 2;
    end else if (f == 1 && !want_up) begin
      x = 2; y = 1;
    end
  endfunction

  function automatic bit predict_reject(
    bit u, bit d, bit j, int jf);
    if (int'(u) + int'(d) + int'(j) > 1) return 1'b1;
    if (u) return m_floor == NF - 1;
    if (d) return m_floor == 0;
    if (j) return (jf >= NF) || (jf == m_floor);
    return 1'b0;
  endfunction

  task automatic clear_inputs();
    up_req   = 1'b0;
    down_req = 1'b0;
    jump_req = 1'b0;
    map_ack  = 1'b0;
  endtask

  // Kind: 0 up, 1 down, 2 jump. Starts just after a
  // negedge in IDLE. Checks every cycle of the
  // transit against the expected timeline.
  task automatic run_transit(
    input int kind, input int jf,
    input int ack_delay, input bit noise,
    input string name);
    int tgt, nx, ny, p, total;
    logic [31:0] exp;
    tgt = (kind == 0) ? m_floor + 1 :
          (kind == 1) ? m_floor - 1 : jf;
    stairs(tgt, kind == 1, nx, ny);
    p = FS + 2 + ack_delay;
    total = 2 * FS + 4 + ack_delay;
    up_req     = (kind == 0);
    down_req   = (kind == 1);
    jump_req   = (kind == 2);
    jump_floor = FW'(jf);
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c <= FS)
        exp = vec(m_floor, m_x, m_y, FS - c + 1,
                  0, 1, 0, 0);
      else if (c <= FS + 1 + ack_delay)
        exp = vec(tgt, m_x, m_y, 0, 1, 1, 0, 0);
      else if (c == p)
        exp = vec(tgt, m_x, m_y, 0, 0, 1, 0, 0);
      else if (c < total)
        exp = vec(tgt, nx, ny, c - p - 1,
                  0, 1, 0, 0);
      else
        exp = vec(tgt, nx, ny, FS, 0, 0, 1, 0);
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL %s cyc %0d: got %h want %h",
                 name, c, obs(), exp);
      end
      if (c == FS + 1 + ack_delay) begin
        map_ack = 1'b1;
      end else if (noise && c < total) begin
        if (c < FS + 1 || c > FS + 1 + ack_delay)
          map_ack = 1'($urandom_range(0, 1));
        up_req     = 1'($urandom_range(0, 1));
        down_req   = 1'($urandom_range(0, 1));
        jump_req   = 1'($urandom_range(0, 1));
        jump_floor = FW'($urandom_range(0, 17));
      end
    end
    m_floor = tgt;
    m_x = nx;
    m_y = ny;
    @(negedge clk);
    exp = vec(m_floor, m_x, m_y, FS, 0, 0, 0, 0);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL %s after_done: got %h want %h",
               name, obs(), exp);
    end
  endtask

  task automatic test_reject(
    input bit u, input bit d, input bit j,
    input int jf, input string name);
    logic [31:0] exp;
    up_req     = u;
    down_req   = d;
    jump_req   = j;
    jump_floor = FW'(jf);
    @(negedge clk);
    clear_inputs();
    exp = vec(m_floor, m_x, m_y, FS, 0, 0, 0, 1);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL %s pulse: got %h want %h",
               name, obs(), exp);
    end
    @(negedge clk);
    exp = vec(m_floor, m_x, m_y, FS, 0, 0, 0, 0);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL %s settle: got %h want %h",
               name, obs(), exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    rst = 1'b1;
    clear_inputs();
    jump_floor = '0;
    repeat (2) @(negedge clk);
    exp = vec(0, 0, 0, FS, 0, 0, 0, 0);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL reset_hold: got %h want %h",
               obs(), exp);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL reset_release: got %h want %h",
               obs(), exp);
    end
    m_floor = 0;
    m_x = 0;
    m_y = 0;
  endtask

  task automatic test_up_first();
    run_transit(0, 0, 3, 1'b0, "up_from_0");
    checks++;
    if (player_x !== 4'd2 || player_y !== 4'd1) begin
      errors++;
      $display("FAIL up_place: got (%0d,%0d) want (2,1)",
               player_x, player_y);
    end
  endtask

  task automatic test_down();
    run_transit(1, 0, 1, 1'b1, "down_from_1");
    checks++;
    if (player_x !== 4'd1 || player_y !== 4'd2) begin
      errors++;
      $display("FAIL down_place: got (%0d,%0d) want (1,2)",
               player_x, player_y);
    end
    test_reject(0, 1, 0, 0, "down_at_0");
  endtask

  task automatic test_jump_busy();
    run_transit(2, 1, 2, 1'b1, "jump_to_1");
    checks++;
    if (player_x !== 4'd2 || player_y !== 4'd1) begin
      errors++;
      $display("FAIL jump_place: got (%0d,%0d) want (2,1)",
               player_x, player_y);
    end
  endtask

  task automatic test_limits();
    run_transit(2, 15, 0, 1'b0, "jump_to_15");
    test_reject(1, 0, 0, 0, "up_at_15");
    run_transit(2, 5, 4, 1'b1, "jump_to_5");
    test_reject(1, 1, 0, 0, "up_down_same");
    test_reject(0, 0, 1, 16, "jump_oob");
    test_reject(0, 0, 1, 5, "jump_same");
    test_reject(1, 0, 1, 3, "up_jump_same");
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    up_req = 1'b1;
    for (int c = 1; c <= FS + 2; c++) begin
      @(negedge clk);
      clear_inputs();
    end
    checks++;
    if (map_req !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_load: got mr=%b b=%b want 1 1",
               map_req, busy);
    end
    rst = 1'b1;
    #1;
    exp = vec(0, 0, 0, FS, 0, 0, 0, 0);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL mid_rst_async: got %h want %h",
               obs(), exp);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL mid_rst_after: got %h want %h",
               obs(), exp);
    end
    m_floor = 0;
    m_x = 0;
    m_y = 0;
    run_transit(0, 0, 3, 1'b0, "up_after_rst");
  endtask

  task automatic test_random();
    int kind, jf, pick;
    bit u, d, j;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      jf = $urandom_range(0, 17);
      u = 0; d = 0; j = 0;
      unique case (kind)
        0: u = 1;
        1: d = 1;
        2: j = 1;
        default: begin
          pick = $urandom_range(0, 3);
          u = (pick != 0);
          d = (pick != 1);
          j = (pick != 2);
        end
      endcase
      if (predict_reject(u, d, j, jf)) begin
        test_reject(u, d, j, jf, "rand_reject");
      end else begin
        run_transit(kind, jf,
                    $urandom_range(0, 5), 1'b1,
                    "rand_move");
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_first();
    test_down();
    test_jump_busy();
    test_limits();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/floor_transit.md
FLOOR_TRANSIT -- requirements
Module: floor_transit

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 16, meaning the number of floors; legal range is 2..2^FLOOR_W.
REQ-002 SHALL have parameter FLOOR_W, default 16, meaning the floor index width.
REQ-003 SHALL have parameter COORD_W, default 4, meaning the grid coordinate width.
REQ-004 SHALL have parameter FADE_STEPS, default 8, meaning the fade length in cycles; legal range is 1..2^FADE_W-1.
REQ-005 SHALL have parameter FADE_W, default 4, meaning the fade level width.
REQ-006 SHALL have parameter START_FLOOR / START_X / START_Y, default 0/0/0, meaning the position after reset.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have ports up_req / down_req, input, 1 bit each: a one-cycle request to take the stairs.
REQ-010 SHALL have port jump_req, input, 1 bit: a one-cycle request to jump to jump_floor.
REQ-011 SHALL have port jump_floor, input, FLOOR_W: the jump target.
REQ-012 SHALL have port map_ack, input, 1 bit: the map loader has finished loading the new floor.
REQ-013 SHALL have port floor, output, FLOOR_W: the current floor.
REQ-014 SHALL have ports player_x / player_y, output, COORD_W each: the player position.
REQ-015 SHALL have port map_req, output, 1 bit: a level request to load the current floor.
REQ-016 SHALL have port fade_level, output, FADE_W: screen brightness; FADE_STEPS means fully visible.
REQ-017 SHALL have ports busy / done / reject, output, 1 bit each: busy is high while in transit; done and reject are one-cycle pulses.

Function
REQ-018 SHALL use the FSM states IDLE, FADE_OUT, LOAD, PLACE and FADE_IN.
REQ-019 SHALL sample requests only in IDLE, and SHALL ignore all requests in every other state (no reject pulse).
REQ-020 SHALL in IDLE raise reject for one cycle, with no state change, when more than one of up/down/jump is asserted at once.
REQ-021 SHALL in IDLE raise reject for up_req when floor==NUM_FLOORS-1.
REQ-022 SHALL in IDLE raise reject for down_req when floor==0.
REQ-023 SHALL in IDLE raise reject for jump_req when jump_floor>=NUM_FLOORS or jump_floor==floor.
REQ-024 SHALL, for an accepted request, latch the target floor (floor+1, floor-1 or jump_floor) and the direction, then enter FADE_OUT on the next edge; busy=1 from that edge.
REQ-025 SHALL in FADE_OUT decrement fade_level by 1 per cycle; when fade_level reaches 0, floor SHALL take the target value and the state SHALL become LOAD.
REQ-026 SHALL in LOAD hold map_req=1; map_ack sampled high SHALL clear map_req and move the FSM to PLACE on the same edge; LOAD waits without limit.
REQ-027 SHALL ignore map_ack outside LOAD.
REQ-028 SHALL in PLACE, lasting one cycle, load player_x/y from the stair table:
- for an up move, the new floor's down-stair coordinates;
- for a down move, the new floor's up-stair coordinates;
- for a jump, the new floor's down-stair coordinates.
REQ-029 SHALL in FADE_IN increment fade_level by 1 per cycle up to FADE_STEPS, then return to IDLE with busy=0 and done=1 for one cycle.
REQ-030 SHALL take exactly 2·FADE_STEPS+2+(LOAD cycles) cycles from the accept edge to the done pulse.
REQ-031 SHALL return the stair table entry for floors 0 and 1 as follows:
- floor 0: down(0,0), up(1,2);
- floor 1: down(2,1), up(0,0);
- any other floor: all zeros, unless overridden by the package.
REQ-032 SHALL keep player_x/y unchanged outside PLACE.

Reset
REQ-033 SHALL, on rst asserted at any time (including mid-transit), immediately set state=IDLE, floor=START_FLOOR, player_x/y=START_X/START_Y, fade_level=FADE_STEPS, map_req=0, busy=0, done=0, reject=0.
REQ-034 SHALL discard any pending target on reset.

Structure
REQ-035 SHALL place the FSM state encoding and the stair coordinate table constants in the shared game package.
REQ-036 SHALL implement the lookup as a combinational sub-module stair_table (floor in; up_x/up_y/down_x/down_y out, COORD_W wide), instantiated once.

Verification (FADE_STEPS=4, NUM_FLOORS=16)
REQ-037 SHALL verify: from reset, up_req at floor 0 -> fade 4,3,2,1,0, floor=1, map_req high; map_ack after 3 cycles -> player (2,1), fade 1..4, done pulse, busy low.
REQ-038 SHALL verify: at floor 1, down_req -> floor=0, player (1,2); at floor 0, down_req -> reject pulse and no state change.
REQ-039 SHALL verify: at floor 15, up_req -> reject; up_req+down_req in the same cycle at floor 5 -> reject; jump_floor=16 -> reject; jump_floor=current -> reject.
REQ-040 SHALL verify: jump_req to floor 1 from floor 0 -> player (2,1) after map_ack; requests pulsed while busy -> ignored, with no reject.
REQ-041 SHALL verify: rst asserted during LOAD -> next observation shows floor=0, player (0,0), fade 4, map_req 0; a later up_req behaves as in REQ-037.
